// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared definitions for the EX-stage hazard/forwarding controller:
// instruction encodings, forwarding select codes and IR decode helpers.
package hazard_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_MM = 2'b01,
        FWD_WB = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic [4:0] dest;
        logic       dest_valid;
        logic [4:0] rs;
        logic       rs_used;
        logic [4:0] rt;
        logic       rt_used;
    } instr_fields_t;

    function automatic logic is_alu_rtype(input logic [31:0] ir);
        return (ir[31:26] == OP_RTYPE) && ((ir[5:0] == FN_ADD) || (ir[5:0] == FN_SUB));
    endfunction

    // Register 0 doubles as "no destination", so callers only need a compare with zero.
    function automatic logic [4:0] dest_of(input logic [31:0] ir);
        if (is_alu_rtype(ir)) return ir[15:11];
        if ((ir[31:26] == OP_ADDI) || (ir[31:26] == OP_LW)) return ir[20:16];
        return 5'd0;
    endfunction

    function automatic logic uses_rs(input logic [31:0] ir);
        return is_alu_rtype(ir) || (ir[31:26] == OP_ADDI) ||
               (ir[31:26] == OP_LW) || (ir[31:26] == OP_SW);
    endfunction

    function automatic logic uses_rt(input logic [31:0] ir);
        return is_alu_rtype(ir) || (ir[31:26] == OP_SW);
    endfunction

    // The youngest in-flight producer (currently in EX) takes precedence over MEM.
    function automatic fwd_sel_e fwd_pick(input logic used, input logic [4:0] src,
                                          input instr_fields_t ex_f, input instr_fields_t mm_f);
        if (!used) return FWD_RF;
        if (ex_f.dest_valid && (ex_f.dest == src)) return FWD_MM;
        if (mm_f.dest_valid && (mm_f.dest == src)) return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// Decode-side and datapath-side signals of the hazard/forwarding controller.
interface hazard_forward_ctrl_if #(parameter int STALL_CNT_W = 16);

    logic [31:0]            id_IR;
    logic                   id_valid;
    logic                   flush;
    logic [31:0]            ex_IR;
    logic [31:0]            m_IR;
    logic [31:0]            w_IR;
    logic [1:0]             fwd_sel_a;
    logic [1:0]             fwd_sel_b;
    logic                   stall;
    logic [STALL_CNT_W-1:0] stall_count;

    modport master (
        output id_IR, id_valid, flush,
        input  ex_IR, m_IR, w_IR, fwd_sel_a, fwd_sel_b, stall, stall_count
    );

    modport slave (
        input  id_IR, id_valid, flush,
        output ex_IR, m_IR, w_IR, fwd_sel_a, fwd_sel_b, stall, stall_count
    );

endinterface

// File: rtl/hazard_forward_ctrl_fields.sv
// Combinational decode of one instruction word into its register usage.
module instr_fields
    import hazard_pkg::*;
(
    input  logic [31:0]   ir,
    output instr_fields_t fields
);

    always_comb begin
        fields.dest       = dest_of(ir);
        fields.dest_valid = (dest_of(ir) != 5'd0);
        fields.rs         = ir[25:21];
        fields.rs_used    = uses_rs(ir);
        fields.rt         = ir[20:16];
        fields.rt_used    = uses_rt(ir);
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Tracks EX/MEM/WB instructions, registers ALU operand forwarding selects
// and raises the one-cycle load-use stall.
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int          STALL_CNT_W = 16,
    parameter logic [31:0] NOP_WORD    = hazard_pkg::NOP_WORD
) (
    input  logic                 clock,
    input  logic                 reset,
    hazard_forward_ctrl_if.slave bus
);

    logic [31:0]            ex_ir_q, ex_ir_d;
    logic [31:0]            m_ir_q, m_ir_d;
    logic [31:0]            w_ir_q, w_ir_d;
    fwd_sel_e               fwd_sel_a_q, fwd_sel_a_d;
    fwd_sel_e               fwd_sel_b_q, fwd_sel_b_d;
    logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

    logic [31:0]   id_ir;
    instr_fields_t id_f, ex_f, mm_f;
    logic          load_use;
    logic          stall;
    logic          advance;
    logic          unused_fields;

    assign id_ir = bus.id_valid ? bus.id_IR : NOP_WORD;

    instr_fields u_id_fields (.ir(id_ir),   .fields(id_f));
    instr_fields u_ex_fields (.ir(ex_ir_q), .fields(ex_f));
    instr_fields u_mm_fields (.ir(m_ir_q),  .fields(mm_f));

    // A load's data only exists from WB on, so a consumer directly behind it must wait one cycle.
    assign load_use = (ex_ir_q[31:26] == OP_LW) && ex_f.dest_valid &&
                      ((id_f.rs_used && (id_f.rs == ex_f.dest)) ||
                       (id_f.rt_used && (id_f.rt == ex_f.dest)));
    assign stall    = load_use && !bus.flush && !reset;
    assign advance  = !bus.flush && !load_use;

    always_comb begin
        ex_ir_d       = NOP_WORD;
        fwd_sel_a_d   = FWD_RF;
        fwd_sel_b_d   = FWD_RF;
        if (advance) begin
            ex_ir_d     = id_ir;
            fwd_sel_a_d = fwd_pick(id_f.rs_used, id_f.rs, ex_f, mm_f);
            fwd_sel_b_d = fwd_pick(id_f.rt_used, id_f.rt, ex_f, mm_f);
        end
        m_ir_d        = ex_ir_q;
        w_ir_d        = m_ir_q;
        stall_count_d = stall_count_q;
        if (stall && !(&stall_count_q)) begin
            stall_count_d = stall_count_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_ir_q       <= NOP_WORD;
            m_ir_q        <= NOP_WORD;
            w_ir_q        <= NOP_WORD;
            fwd_sel_a_q   <= FWD_RF;
            fwd_sel_b_q   <= FWD_RF;
            stall_count_q <= '0;
        end else begin
            ex_ir_q       <= ex_ir_d;
            m_ir_q        <= m_ir_d;
            w_ir_q        <= w_ir_d;
            fwd_sel_a_q   <= fwd_sel_a_d;
            fwd_sel_b_q   <= fwd_sel_b_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.ex_IR       = ex_ir_q;
    assign bus.m_IR        = m_ir_q;
    assign bus.w_IR        = w_ir_q;
    assign bus.fwd_sel_a   = fwd_sel_a_q;
    assign bus.fwd_sel_b   = fwd_sel_b_q;
    assign bus.stall       = stall;
    assign bus.stall_count = stall_count_q;

    // Decoded fields that no hazard check needs for that particular stage.
    assign unused_fields = ^{id_f.dest, id_f.dest_valid, ex_f.rs, ex_f.rs_used, ex_f.rt,
                             ex_f.rt_used, mm_f.rs, mm_f.rs_used, mm_f.rt, mm_f.rt_used};

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl: directed hazard scenarios plus
// randomized traffic against an instruction-level pipeline model.
module tb_hazard_forward_ctrl;

    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22;
    localparam logic [5:0] O_ADDI = 6'h08, O_LW = 6'h23, O_SW = 6'h2B;

    logic clock;
    logic reset;
    int   total;
    int   bad;

    hazard_forward_ctrl_if #(.STALL_CNT_W(16)) bus ();
    hazard_forward_ctrl_if #(.STALL_CNT_W(4))  bus4 ();

    hazard_forward_ctrl #(.STALL_CNT_W(16)) dut (.clock(clock), .reset(reset), .bus(bus));
    hazard_forward_ctrl #(.STALL_CNT_W(4))  dut4 (.clock(clock), .reset(reset), .bus(bus4));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Model state: instructions per stage, registered selects and stall tally.
    logic [31:0] m_ex, m_mm, m_wb;
    logic [1:0]  m_fa, m_fb;
    int          m_cnt;
    logic        obs_stall, exp_stall;

    function automatic logic [31:0] mk_r(input logic [5:0] fn, input int rd, input int rs, input int rt);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input int rt, input int rs, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic int ref_dest(input logic [31:0] ir);
        int op = int'(ir[31:26]);
        int fn = int'(ir[5:0]);
        if (op == 0 && (fn == 32 || fn == 34)) return int'(ir[15:11]);
        if (op == 8 || op == 35) return int'(ir[20:16]);
        return 0;
    endfunction

    function automatic int ref_src_a(input logic [31:0] ir);
        int op = int'(ir[31:26]);
        int fn = int'(ir[5:0]);
        if ((op == 0 && (fn == 32 || fn == 34)) || op == 8 || op == 35 || op == 43) return int'(ir[25:21]);
        return -1;
    endfunction

    function automatic int ref_src_b(input logic [31:0] ir);
        int op = int'(ir[31:26]);
        int fn = int'(ir[5:0]);
        if ((op == 0 && (fn == 32 || fn == 34)) || op == 43) return int'(ir[20:16]);
        return -1;
    endfunction

    function automatic logic [1:0] ref_fwd(input int src, input logic [31:0] ex, input logic [31:0] mm);
        if (src < 0) return 2'd0;
        if (ref_dest(ex) != 0 && ref_dest(ex) == src) return 2'd1;
        if (ref_dest(mm) != 0 && ref_dest(mm) == src) return 2'd2;
        return 2'd0;
    endfunction

    // Drive one decode cycle, sample stall mid-cycle, clock it and advance the model.
    task automatic step(input logic [31:0] ir, input logic v, input logic fl, input logic rs);
        logic [31:0] dec;
        int          d;
        logic        adv;
        bus.id_IR    = ir;
        bus.id_valid = v;
        bus.flush    = fl;
        reset        = rs;
        dec          = v ? ir : 32'd0;
        #2;
        obs_stall = bus.stall;
        d = ref_dest(m_ex);
        exp_stall = !rs && !fl && (m_ex[31:26] == O_LW) && d != 0 &&
                    (ref_src_a(dec) == d || ref_src_b(dec) == d);
        @(posedge clock);
        if (rs) begin
            m_ex = 0; m_mm = 0; m_wb = 0; m_fa = 0; m_fb = 0; m_cnt = 0;
        end else begin
            adv  = !fl && !exp_stall;
            m_fa = adv ? ref_fwd(ref_src_a(dec), m_ex, m_mm) : 2'd0;
            m_fb = adv ? ref_fwd(ref_src_b(dec), m_ex, m_mm) : 2'd0;
            m_wb = m_mm;
            m_mm = m_ex;
            m_ex = adv ? dec : 32'd0;
            if (exp_stall && m_cnt < 65535) m_cnt++;
        end
        #1;
    endtask

    task automatic test_reset();
        step(mk_r(F_ADD, 1, 2, 3), 1'b1, 1'b0, 1'b1);
        total++; if (obs_stall !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall got=%b exp=0", obs_stall); end
        total++; if (bus.ex_IR !== 32'd0) begin bad++; $display("[TB] FAIL reset_ex got=%h exp=0", bus.ex_IR); end
        total++; if (bus.m_IR !== 32'd0) begin bad++; $display("[TB] FAIL reset_m got=%h exp=0", bus.m_IR); end
        total++; if (bus.w_IR !== 32'd0) begin bad++; $display("[TB] FAIL reset_w got=%h exp=0", bus.w_IR); end
        total++; if ({bus.fwd_sel_a, bus.fwd_sel_b} !== 4'b0) begin bad++; $display("[TB] FAIL reset_fwd got=%b%b exp=0000", bus.fwd_sel_a, bus.fwd_sel_b); end
        total++; if (bus.stall_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_cnt got=%0d exp=0", bus.stall_count); end
    endtask

    task automatic test_fwd_mm();
        logic seen;
        step(32'd0, 1'b0, 1'b0, 1'b1);
        step(mk_i(O_ADDI, 1, 0, 5), 1'b1, 1'b0, 1'b0);
        seen = obs_stall;
        step(mk_r(F_ADD, 2, 1, 1), 1'b1, 1'b0, 1'b0);
        seen = seen | obs_stall;
        total++; if (bus.ex_IR !== mk_r(F_ADD, 2, 1, 1)) begin bad++; $display("[TB] FAIL mm_ex got=%h exp=%h", bus.ex_IR, mk_r(F_ADD, 2, 1, 1)); end
        total++; if (bus.fwd_sel_a !== 2'b01) begin bad++; $display("[TB] FAIL mm_fwd_a got=%b exp=01", bus.fwd_sel_a); end
        total++; if (bus.fwd_sel_b !== 2'b01) begin bad++; $display("[TB] FAIL mm_fwd_b got=%b exp=01", bus.fwd_sel_b); end
        total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL mm_stall got=%b exp=0", seen); end
    endtask

    task automatic test_fwd_wb();
        step(32'd0, 1'b0, 1'b0, 1'b1);
        step(mk_i(O_ADDI, 3, 0, 9), 1'b1, 1'b0, 1'b0);
        step(mk_i(O_ADDI, 7, 0, 1), 1'b1, 1'b0, 1'b0);
        step(mk_r(F_SUB, 4, 3, 0), 1'b1, 1'b0, 1'b0);
        total++; if (bus.fwd_sel_a !== 2'b10) begin bad++; $display("[TB] FAIL wb_fwd_a got=%b exp=10", bus.fwd_sel_a); end
        total++; if (bus.fwd_sel_b !== 2'b00) begin bad++; $display("[TB] FAIL wb_fwd_b got=%b exp=00", bus.fwd_sel_b); end
        total++; if (bus.m_IR !== mk_i(O_ADDI, 7, 0, 1)) begin bad++; $display("[TB] FAIL wb_m got=%h exp=%h", bus.m_IR, mk_i(O_ADDI, 7, 0, 1)); end
    endtask

    task automatic test_load_use();
        step(32'd0, 1'b0, 1'b0, 1'b1);
        step(mk_i(O_LW, 5, 0, 0), 1'b1, 1'b0, 1'b0);
        step(mk_r(F_ADD, 6, 5, 0), 1'b1, 1'b0, 1'b0);
        total++; if (obs_stall !== 1'b1) begin bad++; $display("[TB] FAIL lu_stall got=%b exp=1", obs_stall); end
        total++; if (bus.ex_IR !== 32'd0) begin bad++; $display("[TB] FAIL lu_bubble got=%h exp=0", bus.ex_IR); end
        step(mk_r(F_ADD, 6, 5, 0), 1'b1, 1'b0, 1'b0);
        total++; if (obs_stall !== 1'b0) begin bad++; $display("[TB] FAIL lu_stall2 got=%b exp=0", obs_stall); end
        total++; if (bus.ex_IR !== mk_r(F_ADD, 6, 5, 0)) begin bad++; $display("[TB] FAIL lu_ex got=%h exp=%h", bus.ex_IR, mk_r(F_ADD, 6, 5, 0)); end
        total++; if (bus.fwd_sel_a !== 2'b10) begin bad++; $display("[TB] FAIL lu_fwd_a got=%b exp=10", bus.fwd_sel_a); end
        total++; if (bus.stall_count !== 16'd1) begin bad++; $display("[TB] FAIL lu_cnt got=%0d exp=1", bus.stall_count); end
    endtask

    task automatic test_zero_and_youngest();
        step(32'd0, 1'b0, 1'b0, 1'b1);
        step(mk_i(O_ADDI, 0, 0, 7), 1'b1, 1'b0, 1'b0);
        step(mk_r(F_ADD, 1, 0, 0), 1'b1, 1'b0, 1'b0);
        total++; if ({bus.fwd_sel_a, bus.fwd_sel_b} !== 4'b0000) begin bad++; $display("[TB] FAIL r0_fwd got=%b%b exp=0000", bus.fwd_sel_a, bus.fwd_sel_b); end
        step(mk_i(O_ADDI, 2, 0, 1), 1'b1, 1'b0, 1'b0);
        step(mk_i(O_ADDI, 2, 2, 1), 1'b1, 1'b0, 1'b0);
        step(mk_r(F_ADD, 8, 2, 0), 1'b1, 1'b0, 1'b0);
        total++; if (bus.fwd_sel_a !== 2'b01) begin bad++; $display("[TB] FAIL young_fwd_a got=%b exp=01", bus.fwd_sel_a); end
        total++; if (bus.fwd_sel_b !== 2'b00) begin bad++; $display("[TB] FAIL young_fwd_b got=%b exp=00", bus.fwd_sel_b); end
    endtask

    task automatic test_flush_stall();
        step(32'd0, 1'b0, 1'b0, 1'b1);
        step(mk_i(O_LW, 5, 0, 0), 1'b1, 1'b0, 1'b0);
        step(mk_r(F_ADD, 6, 5, 0), 1'b1, 1'b1, 1'b0);
        total++; if (obs_stall !== 1'b0) begin bad++; $display("[TB] FAIL fl_stall got=%b exp=0", obs_stall); end
        total++; if (bus.ex_IR !== 32'd0) begin bad++; $display("[TB] FAIL fl_ex got=%h exp=0", bus.ex_IR); end
        total++; if (bus.stall_count !== 16'd0) begin bad++; $display("[TB] FAIL fl_cnt got=%0d exp=0", bus.stall_count); end
        step(mk_r(F_ADD, 6, 5, 0), 1'b1, 1'b0, 1'b0);
        total++; if (bus.fwd_sel_a !== 2'b10) begin bad++; $display("[TB] FAIL fl_fwd_a got=%b exp=10", bus.fwd_sel_a); end
        total++; if (bus.stall_count !== 16'd0) begin bad++; $display("[TB] FAIL fl_cnt2 got=%0d exp=0", bus.stall_count); end
    endtask

    task automatic test_back_to_back();
        step(32'd0, 1'b0, 1'b0, 1'b1);
        step(mk_i(O_LW, 5, 0, 0), 1'b1, 1'b0, 1'b0);
        step(mk_i(O_LW, 6, 5, 4), 1'b1, 1'b0, 1'b0);
        total++; if (obs_stall !== 1'b1) begin bad++; $display("[TB] FAIL b2b_stall1 got=%b exp=1", obs_stall); end
        step(mk_i(O_LW, 6, 5, 4), 1'b1, 1'b0, 1'b0);
        total++; if (bus.fwd_sel_a !== 2'b10) begin bad++; $display("[TB] FAIL b2b_fwd1 got=%b exp=10", bus.fwd_sel_a); end
        step(mk_r(F_ADD, 7, 6, 0), 1'b1, 1'b0, 1'b0);
        total++; if (obs_stall !== 1'b1) begin bad++; $display("[TB] FAIL b2b_stall2 got=%b exp=1", obs_stall); end
        step(mk_r(F_ADD, 7, 6, 0), 1'b1, 1'b0, 1'b0);
        total++; if (bus.fwd_sel_a !== 2'b10) begin bad++; $display("[TB] FAIL b2b_fwd2 got=%b exp=10", bus.fwd_sel_a); end
        total++; if (bus.stall_count !== 16'd2) begin bad++; $display("[TB] FAIL b2b_cnt got=%0d exp=2", bus.stall_count); end
    endtask

    task automatic test_reset_mid_stall();
        step(32'd0, 1'b0, 1'b0, 1'b1);
        step(mk_i(O_LW, 5, 0, 0), 1'b1, 1'b0, 1'b0);
        step(mk_r(F_ADD, 6, 5, 5), 1'b1, 1'b0, 1'b0);
        step(mk_r(F_ADD, 6, 5, 5), 1'b1, 1'b0, 1'b0);
        step(mk_i(O_LW, 5, 6, 0), 1'b1, 1'b0, 1'b0);
        step(mk_r(F_ADD, 9, 5, 0), 1'b1, 1'b0, 1'b1);
        total++; if (obs_stall !== 1'b0) begin bad++; $display("[TB] FAIL rms_stall got=%b exp=0", obs_stall); end
        total++; if ({bus.ex_IR, bus.m_IR, bus.w_IR} !== 96'd0) begin bad++; $display("[TB] FAIL rms_stages got=%h %h %h exp=0", bus.ex_IR, bus.m_IR, bus.w_IR); end
        total++; if ({bus.fwd_sel_a, bus.fwd_sel_b} !== 4'b0000) begin bad++; $display("[TB] FAIL rms_fwd got=%b%b exp=0000", bus.fwd_sel_a, bus.fwd_sel_b); end
        total++; if (bus.stall_count !== 16'd0) begin bad++; $display("[TB] FAIL rms_cnt got=%0d exp=0", bus.stall_count); end
        step(mk_r(F_ADD, 9, 5, 0), 1'b1, 1'b0, 1'b0);
        total++; if (obs_stall !== 1'b0) begin bad++; $display("[TB] FAIL rms_after got=%b exp=0", obs_stall); end
    endtask

    task automatic test_random();
        logic [31:0] ir;
        int          kind;
        step(32'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 6);
            case (kind)
                0: ir = mk_r(F_ADD, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                1: ir = mk_r(F_SUB, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                2: ir = mk_i(O_ADDI, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 65535));
                3: ir = mk_i(O_LW, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 65535));
                4: ir = mk_i(O_SW, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 65535));
                5: ir = mk_i(6'h04, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 65535));
                default: ir = mk_r(6'h24, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            endcase
            step(ir, ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) == 0));
            total++; if (obs_stall !== exp_stall) begin bad++; $display("[TB] FAIL rnd_stall cyc=%0d got=%b exp=%b", i, obs_stall, exp_stall); end
            total++; if (bus.ex_IR !== m_ex) begin bad++; $display("[TB] FAIL rnd_ex cyc=%0d got=%h exp=%h", i, bus.ex_IR, m_ex); end
            total++; if (bus.m_IR !== m_mm) begin bad++; $display("[TB] FAIL rnd_m cyc=%0d got=%h exp=%h", i, bus.m_IR, m_mm); end
            total++; if (bus.w_IR !== m_wb) begin bad++; $display("[TB] FAIL rnd_w cyc=%0d got=%h exp=%h", i, bus.w_IR, m_wb); end
            total++; if (bus.fwd_sel_a !== m_fa) begin bad++; $display("[TB] FAIL rnd_fwd_a cyc=%0d got=%b exp=%b", i, bus.fwd_sel_a, m_fa); end
            total++; if (bus.fwd_sel_b !== m_fb) begin bad++; $display("[TB] FAIL rnd_fwd_b cyc=%0d got=%b exp=%b", i, bus.fwd_sel_b, m_fb); end
            total++; if (bus.stall_count !== 16'(m_cnt)) begin bad++; $display("[TB] FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", i, bus.stall_count, m_cnt); end
        end
    endtask

    // A self-dependent load stalls every other cycle, so 2k edges give k stalls.
    task automatic test_saturation();
        bus4.id_IR    = mk_i(O_LW, 5, 5, 0);
        bus4.id_valid = 1'b1;
        bus4.flush    = 1'b0;
        step(32'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(32'd0, 1'b0, 1'b0, 1'b0);
        total++; if (bus4.stall_count !== 4'd10) begin bad++; $display("[TB] FAIL sat_mid got=%0d exp=10", bus4.stall_count); end
        for (int i = 0; i < 12; i++) step(32'd0, 1'b0, 1'b0, 1'b0);
        total++; if (bus4.stall_count !== 4'hF) begin bad++; $display("[TB] FAIL sat_full got=%0d exp=15", bus4.stall_count); end
        for (int i = 0; i < 8; i++) step(32'd0, 1'b0, 1'b0, 1'b0);
        total++; if (bus4.stall_count !== 4'hF) begin bad++; $display("[TB] FAIL sat_hold got=%0d exp=15", bus4.stall_count); end
        bus4.id_valid = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        m_ex = 0; m_mm = 0; m_wb = 0; m_fa = 0; m_fb = 0; m_cnt = 0;
        reset         = 1'b1;
        bus.id_IR     = 32'd0;
        bus.id_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus4.id_IR    = 32'd0;
        bus4.id_valid = 1'b0;
        bus4.flush    = 1'b0;
        test_reset();
        test_fwd_mm();
        test_fwd_wb();
        test_load_use();
        test_zero_and_youngest();
        test_flush_stall();
        test_back_to_back();
        test_reset_mid_stall();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_forward_ctrl.md
Name: hazard_forward_ctrl

Overview:
- Pipeline controller for the EX-stage ALU.
- Tracks the instructions in EX, MEM and WB and owns the ex/mm/wb instruction registers the datapath consumes.
- Generates registered forwarding selects for both ALU operands and the load-use stall/bubble.
- Sits between decode and the ALU and replaces ad-hoc per-register scoreboarding with a stage-tracked scheme.

Parameters:
- STALL_CNT_W, 16, width of the saturating stall counter.
- NOP_WORD, 32'h0000_0000, instruction injected as a bubble; opcode 0, funct 0, no destination.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; dominates all other inputs.
- id_IR  in  32  instruction currently in decode.
- id_valid  in  1  id_IR holds a real instruction; when 0, NOP_WORD is treated as the decode instruction.
- flush  in  1  replace the instruction advancing into EX with NOP_WORD.
- ex_IR  out  32  instruction in EX (feeds ALU IR).
- m_IR  out  32  instruction in MEM.
- w_IR  out  32  instruction in WB.
- fwd_sel_a  out  2  operand A (rs) source: 00 register file, 01 MEM-stage ALU result (saidaULA_mm), 10 WB-stage result (saidaULA_wb), 11 never driven.
- fwd_sel_b  out  2  operand B (rt) source, same encoding.
- stall  out  1  combinational; hold PC and decode this cycle.
- stall_count  out  STALL_CNT_W  number of stall cycles since reset, saturating.

Behaviour:
Decode rules (pure functions, applied to any IR):
- R-type (op 000000, funct 100000 add / 100010 sub): destination rd[15:11]; sources rs[25:21] and rt[20:16].
- addi (001000): destination rt; source rs.
- lw (100011): destination rt; source rs.
- sw (101011): no destination; sources rs and rt.
- Any other encoding: no destination, no sources.
- A destination of register 0 counts as no destination.

Stall:
- stall = 1 when ex_IR is lw with destination D != 0 and a source of the decode instruction equals D.
- stall is forced to 0 when flush = 1 or reset = 1.

Per rising edge, in priority order:
- reset:
  - ex_IR, m_IR and w_IR <= NOP_WORD.
  - fwd_sel_a and fwd_sel_b <= 00.
  - stall_count <= 0.
  - stall reads 0 in the same cycle.
- Otherwise, m_IR <= ex_IR and w_IR <= m_IR every cycle; the pipeline never freezes below EX.
- ex_IR:
  - NOP_WORD if flush or stall.
  - Otherwise id_IR if id_valid, else NOP_WORD.
- fwd_sel_x, for source field s of the instruction being loaded into ex_IR:
  - 01 if s matches ex_IR's destination.
  - Else 10 if s matches m_IR's destination.
  - Else 00.
  - The youngest producer wins.
  - For a bubble, or for an unused source field, fwd_sel_x = 00.
- stall_count increments on each cycle with stall = 1 and holds at all ones.

Latency and load forwarding:
- Forwarding selects are valid in the same cycle the consumer is present in ex_IR (1-cycle registered latency from decode).
- A lw result is only forwardable from WB. The single stall cycle moves the lw into MEM, so the consumer then receives 10.
- Never 01 from a lw: the stall guarantees this.

Boundary cases:
- A stall lasts exactly one cycle per dependent pair.
- Back-to-back loads each stall independently.
- flush during a would-be stall: bubble inserted, stall = 0, counter does not increment.
- Reset mid-stall: next cycle all stages hold NOP_WORD and stall = 0.

Decomposition:
- Package hazard_pkg holds:
  - opcode/funct constants (OP_RTYPE, OP_ADDI, OP_LW, OP_SW, FN_ADD, FN_SUB);
  - forwarding encodings (FWD_RF, FWD_MM, FWD_WB);
  - NOP_WORD;
  - functions dest_of(IR), uses_rs(IR), uses_rt(IR).
- One sub-module, instr_fields: combinational decode of one IR into {dest, dest_valid, rs, rs_used, rt, rt_used}.
- Three instances: decode, ex, mm.
- Target size: about 200 RTL lines.

Test Plan:
- addi $1,$0,5 then add $2,$1,$1 back-to-back -> with add in ex_IR: fwd_sel_a = fwd_sel_b = 01, stall never 1.
- addi $3,$0,9; addi $7,$0,1; sub $4,$3,$0 -> with sub in EX: fwd_sel_a = 10, fwd_sel_b = 00.
- lw $5,0($0); add $6,$5,$0 -> stall = 1 for exactly one cycle; ex_IR = 0 that cycle; next cycle add in EX with fwd_sel_a = 10; stall_count = 1.
- addi $0,$0,7 then add $1,$0,$0 -> fwd_sel_a = fwd_sel_b = 00; addi $2,$0,1; addi $2,$2,1; add $8,$2,$0 -> fwd_sel_a = 01 (youngest wins, not 10).
- lw $5 then add using $5 with flush = 1 in the stall cycle -> stall = 0, ex_IR = 0, stall_count unchanged.
- reset asserted during a stall cycle -> next edge: ex_IR = m_IR = w_IR = 0, fwd selects 00, stall_count = 0; stall_count saturates at 16'hFFFF under a forced long stall sequence.
